// File: rtl/sinegen_pkg.sv
// Shared types and helpers for the two-requester sine LUT scheduler.
// Holds the FSM state encoding, default widths and the cosine address offset.
package sinegen_pkg;

    localparam int DEF_ADDR_W  = 6;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_LUT_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // A quarter period of the LUT turns a sine address into a cosine address.
    function automatic int quarter_offset(input int addr_w);
        return 1 << (addr_w - 2);
    endfunction

endpackage

// File: rtl/sinegen_sched_if.sv
// Requester-facing bus of the scheduler: burst commands in, tagged samples and done pulses out.
// The master side is the waveform consumer, the slave side is the scheduler.
interface sinegen_sched_if #(
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 8,
    parameter int DATA_W = 8
) ();
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_cos;
    logic [2*ADDR_W-1:0] req_step;
    logic [2*LEN_W-1:0]  req_len;
    logic                sample_valid;
    logic [DATA_W-1:0]   sample_out;
    logic                sample_id;
    logic                sample_last;
    logic [1:0]          done;

    modport master (
        output req_valid, req_cos, req_step, req_len,
        input  req_ready, sample_valid, sample_out, sample_id, sample_last, done
    );

    modport slave (
        input  req_valid, req_cos, req_step, req_len,
        output req_ready, sample_valid, sample_out, sample_id, sample_last, done
    );
endinterface

// File: rtl/sinegen_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the one not granted last.
// The history bit only moves when a grant is actually taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic [1:0] o_grant
);
    logic r_last_grant;

    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (i_accept) begin
            r_last_grant <= o_grant[1];
        end
    end
endmodule

// File: rtl/sinegen_sched.sv
// Shares one sine LUT between two burst requesters: issues one LUT read per cycle,
// returns samples tagged with owner/last after the LUT latency, then pulses done.
module sinegen_sched
    import sinegen_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int LUT_LAT = DEF_LUT_LAT
) (
    input  logic              clk,
    input  logic              reset,
    sinegen_sched_if.slave    req_if,
    input  logic              abort,
    output logic              lut_en,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_data
);
    localparam logic [ADDR_W-1:0] QUARTER = ADDR_W'(quarter_offset(ADDR_W));

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_phase;
    logic [ADDR_W-1:0]  r_step;
    logic [LEN_W-1:0]   r_count;
    logic               r_cos;
    logic               r_owner;
    logic               r_zero;

    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_acc_id;
    logic [LEN_W-1:0]   w_acc_len;
    logic [ADDR_W-1:0]  w_acc_step;
    logic               w_last;
    logic               w_drain_done;

    // Pipeline entry: [2]=issued, [1]=owner, [0]=last
    logic [2:0]         r_pipe [LUT_LAT];
    logic               w_tail_en;
    logic               w_tail_last;

    logic               r_sample_valid;
    logic [DATA_W-1:0]  r_sample_out;
    logic               r_sample_id;
    logic               r_sample_last;
    logic [1:0]         r_done;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (req_if.req_valid),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign req_if.req_ready = (r_state == ST_IDLE) ? w_grant : 2'b00;
    assign w_accept   = |(req_if.req_valid & req_if.req_ready);
    assign w_acc_id   = w_grant[1];
    assign w_acc_len  = req_if.req_len[(w_acc_id ? LEN_W : 0) +: LEN_W];
    assign w_acc_step = req_if.req_step[(w_acc_id ? ADDR_W : 0) +: ADDR_W];

    assign w_last       = (r_count == LEN_W'(1)) | abort;
    assign w_tail_en    = r_pipe[LUT_LAT-1][2];
    assign w_tail_last  = r_pipe[LUT_LAT-1][0];
    // A zero-length burst has nothing in flight, so it completes one cycle after accept.
    assign w_drain_done = (r_state == ST_DRAIN) & (r_zero | (w_tail_en & w_tail_last));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        lut_en       = 1'b0;
        lut_addr     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_acc_len != '0) ? ST_RUN : ST_DRAIN;
                end
            end
            ST_RUN: begin
                lut_en   = 1'b1;
                lut_addr = r_phase + (r_cos ? QUARTER : '0);
                if (w_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= '0;
            r_step  <= '0;
            r_count <= '0;
            r_cos   <= 1'b0;
            r_owner <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_phase <= '0;
            r_step  <= w_acc_step;
            r_count <= w_acc_len;
            r_cos   <= req_if.req_cos[w_acc_id];
            r_owner <= w_acc_id;
            r_zero  <= (w_acc_len == '0);
        end else if (r_state == ST_RUN) begin
            r_phase <= r_phase + r_step;
            r_count <= r_count - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe[0] <= '0;
        end else begin
            r_pipe[0] <= {lut_en, r_owner, lut_en & w_last};
        end
    end

    generate
        for (genvar gi = 1; gi < LUT_LAT; gi++) begin : g_pipe
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pipe[gi] <= '0;
                end else begin
                    r_pipe[gi] <= r_pipe[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample_valid <= 1'b0;
            r_sample_out   <= '0;
            r_sample_id    <= 1'b0;
            r_sample_last  <= 1'b0;
            r_done         <= 2'b00;
        end else begin
            r_sample_valid <= w_tail_en;
            r_sample_last  <= w_tail_en & w_tail_last;
            if (w_tail_en) begin
                r_sample_out <= lut_data;
                r_sample_id  <= r_pipe[LUT_LAT-1][1];
            end
            r_done <= 2'b00;
            if (w_drain_done) begin
                r_done[r_owner] <= 1'b1;
            end
        end
    end

    assign req_if.sample_valid = r_sample_valid;
    assign req_if.sample_out   = r_sample_out;
    assign req_if.sample_id    = r_sample_id;
    assign req_if.sample_last  = r_sample_last;
    assign req_if.done         = r_done;
endmodule
